// File: rtl/hex_sr_multi_if.sv
// Bus between the Tiny Tapeout pin wrapper and the shift-register core.
// The wrapper side is the master (drives mode/data), the core is the slave.
interface hex_sr_multi_if #(
  parameter int WIDTH  = 6,
  parameter int LENGTH = 200
) ();
  localparam int FW  = $clog2(LENGTH + 1);
  localparam int PW0 = $clog2(LENGTH);
  localparam int PW  = (PW0 < 1) ? 1 : PW0;

  logic [1:0]       mode;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic [FW-1:0]    fill;
  logic             full;
  logic             empty;
  logic [PW-1:0]    phase;
  logic             sync;

  modport master (
    output mode, data_in,
    input  data_out, fill, full, empty, phase, sync
  );

  modport slave (
    input  mode, data_in,
    output data_out, fill, full, empty, phase, sync
  );
endinterface

// File: rtl/hex_sr_multi.sv
// Multi-channel shift register: WIDTH independent bit lanes of LENGTH stages,
// sharing one mode decode, fill counter and rotation-phase counter.

// One bit lane. Stage 0 is the input end, stage LENGTH-1 is the output.
module hex_sr_lane #(
  parameter int LENGTH = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mode_i,
  input  logic       din_i,
  output logic       dout_o
);
  localparam logic [1:0] M_HOLD   = 2'b00;
  localparam logic [1:0] M_LOAD   = 2'b01;
  localparam logic [1:0] M_RECIRC = 2'b10;

  logic [LENGTH-1:0] stage_q, stage_d;
  logic              src;

  // Pick what enters stage 0; every non-HOLD mode shifts by one.
  always_comb begin
    src     = 1'b0;
    stage_d = stage_q;
    case (mode_i)
      M_LOAD:   src = din_i;
      M_RECIRC: src = stage_q[LENGTH-1];
      default:  src = 1'b0;
    endcase
    if (mode_i != M_HOLD) stage_d = {stage_q[LENGTH-2:0], src};
  end

  // Stage storage; reset clears contents so data_out reads 0 immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stage_q <= '0;
    else        stage_q <= stage_d;
  end

  assign dout_o = stage_q[LENGTH-1];
endmodule

module hex_sr_multi #(
  parameter int WIDTH  = 6,
  parameter int LENGTH = 200
) (
  input  logic           clk,
  input  logic           rst_n,
  hex_sr_multi_if.slave  bus
);
  localparam int FW  = $clog2(LENGTH + 1);
  localparam int PW0 = $clog2(LENGTH);
  localparam int PW  = (PW0 < 1) ? 1 : PW0;

  localparam logic [1:0] M_HOLD  = 2'b00;
  localparam logic [1:0] M_LOAD  = 2'b01;
  localparam logic [1:0] M_FLUSH = 2'b11;

  logic [FW-1:0] fill_q, fill_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [WIDTH-1:0] lane_out;

  // One independent lane per channel; all lanes see the same mode.
  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    hex_sr_lane #(.LENGTH(LENGTH)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .mode_i (bus.mode),
      .din_i  (bus.data_in[g]),
      .dout_o (lane_out[g])
    );
  end

  // Fill tracking (saturating on LOAD, cleared by FLUSH) and phase advance
  // with an explicit wrap so non-power-of-two depths count exactly.
  always_comb begin
    fill_d  = fill_q;
    phase_d = phase_q;
    if (bus.mode != M_HOLD)
      phase_d = (phase_q == PW'(LENGTH - 1)) ? '0 : phase_q + 1'b1;
    if (bus.mode == M_LOAD && fill_q != FW'(LENGTH))
      fill_d = fill_q + 1'b1;
    else if (bus.mode == M_FLUSH)
      fill_d = '0;
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q  <= '0;
      phase_q <= '0;
    end else begin
      fill_q  <= fill_d;
      phase_q <= phase_d;
    end
  end

  assign bus.data_out = lane_out;
  assign bus.fill     = fill_q;
  assign bus.phase    = phase_q;
  assign bus.full     = (fill_q == FW'(LENGTH));
  assign bus.empty    = (fill_q == '0);
  assign bus.sync     = (phase_q == '0);
endmodule

// File: tb/tb_hex_sr_multi.sv
// Directed bench: DUT A is WIDTH=6/LENGTH=4, DUT B is WIDTH=1/LENGTH=5.
module tb_hex_sr_multi;
  localparam logic [1:0] H = 2'b00, L = 2'b01, R = 2'b10, F = 2'b11;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  hex_sr_multi_if #(.WIDTH(6), .LENGTH(4)) bus_a ();
  hex_sr_multi_if #(.WIDTH(1), .LENGTH(5)) bus_b ();

  hex_sr_multi #(.WIDTH(6), .LENGTH(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  hex_sr_multi #(.WIDTH(1), .LENGTH(5)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // One edge on DUT A (B held), then settle 1 time unit past the edge.
  task automatic tick_a(input logic [1:0] m, input logic [5:0] d);
    bus_a.mode = m; bus_a.data_in = d;
    bus_b.mode = H; bus_b.data_in = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic tick_b(input logic [1:0] m, input logic d);
    bus_a.mode = H; bus_a.data_in = '0;
    bus_b.mode = m; bus_b.data_in = d;
    @(posedge clk); #1;
  endtask

  task automatic chk_a(input string tag, input logic [5:0] dout, input logic [2:0] fill,
                       input logic [1:0] phase);
    chk({tag, ".dout"},  32'(bus_a.data_out), 32'(dout));
    chk({tag, ".fill"},  32'(bus_a.fill), 32'(fill));
    chk({tag, ".full"},  32'(bus_a.full), 32'(fill == 3'd4));
    chk({tag, ".empty"}, 32'(bus_a.empty), 32'(fill == 3'd0));
    chk({tag, ".phase"}, 32'(bus_a.phase), 32'(phase));
    chk({tag, ".sync"},  32'(bus_a.sync), 32'(phase == 2'd0));
  endtask

  logic [1:0] b_mode  [12] = '{L, L, R, L, R, R, L, L, L, R, L, R};
  logic [2:0] b_phase [12] = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 1, 2};
  logic [2:0] b_fill  [12] = '{1, 2, 2, 3, 3, 3, 4, 5, 5, 5, 5, 5};
  logic [5:0] rc_exp  [4]  = '{6'h03, 6'h04, 6'h05, 6'h02};
  int         syncs;

  initial begin
    bus_a.mode = H; bus_a.data_in = '0;
    bus_b.mode = H; bus_b.data_in = '0;

    // Reset pulsed between edges; outputs must clear without a clock.
    #3 rst_n = 1'b0;
    #1 chk_a("rst", 6'h00, 3'd0, 2'd0);
    chk("rst.b.phase", 32'(bus_b.phase), 32'd0);
    chk("rst.b.fill",  32'(bus_b.fill), 32'd0);
    #2 rst_n = 1'b1;

    // Load latency: 4 loads to reach the output.
    tick_a(L, 6'h01); chk_a("ld1", 6'h00, 3'd1, 2'd1);
    tick_a(L, 6'h02); chk_a("ld2", 6'h00, 3'd2, 2'd2);
    tick_a(L, 6'h03); chk_a("ld3", 6'h00, 3'd3, 2'd3);
    tick_a(L, 6'h04); chk_a("ld4", 6'h01, 3'd4, 2'd0);
    tick_a(L, 6'h05); chk_a("ld5", 6'h02, 3'd4, 2'd1);

    // Recirculate a full lap: contents come back, sync once.
    syncs = 0;
    for (int i = 0; i < 4; i++) begin
      tick_a(R, 6'h3f);
      chk($sformatf("rc%0d.dout", i), 32'(bus_a.data_out), 32'(rc_exp[i]));
      chk($sformatf("rc%0d.fill", i), 32'(bus_a.fill), 32'd4);
      if (bus_a.sync) syncs++;
    end
    chk("rc.syncs", syncs, 32'd1);
    chk_a("rc.end", 6'h02, 3'd4, 2'd1);

    // Hold freezes everything, even with data_in toggling.
    for (int i = 0; i < 10; i++) begin
      tick_a(H, 6'(i * 7));
      chk_a($sformatf("hold%0d", i), 6'h02, 3'd4, 2'd1);
    end

    // Asynchronous reset in the middle of recirculation.
    tick_a(R, 6'h00); chk_a("rc5", 6'h03, 3'd4, 2'd2);
    #2 rst_n = 1'b0;
    #1 chk_a("rst2", 6'h00, 3'd0, 2'd0);
    #2 rst_n = 1'b1;
    tick_a(L, 6'h3f); chk_a("post_rst", 6'h00, 3'd1, 2'd1);

    // Flush: fill drops on first edge, old words drain, then zeros.
    tick_a(L, 6'h11);
    tick_a(L, 6'h22);
    tick_a(L, 6'h33); chk_a("full2", 6'h3f, 3'd4, 2'd0);
    tick_a(F, 6'h3f); chk_a("fl1", 6'h11, 3'd0, 2'd1);
    tick_a(F, 6'h3f); chk_a("fl2", 6'h22, 3'd0, 2'd2);
    tick_a(F, 6'h3f); chk_a("fl3", 6'h33, 3'd0, 2'd3);
    tick_a(F, 6'h3f); chk_a("fl4", 6'h00, 3'd0, 2'd0);
    for (int i = 0; i < 4; i++) begin
      tick_a(R, 6'h00);
      chk($sformatf("zero%0d", i), 32'(bus_a.data_out), 32'd0);
    end

    // LENGTH=5 phase wrap, holds interleaved after every third shift.
    for (int i = 0; i < 12; i++) begin
      tick_b(b_mode[i], 1'(i));
      chk($sformatf("b%0d.phase", i), 32'(bus_b.phase), 32'(b_phase[i]));
      chk($sformatf("b%0d.sync", i),  32'(bus_b.sync), 32'(b_phase[i] == 3'd0));
      chk($sformatf("b%0d.fill", i),  32'(bus_b.fill), 32'(b_fill[i]));
      chk($sformatf("b%0d.full", i),  32'(bus_b.full), 32'(b_fill[i] == 3'd5));
      if (i % 3 == 2) begin
        tick_b(H, 1'b1);
        chk($sformatf("bh%0d.phase", i), 32'(bus_b.phase), 32'(b_phase[i]));
        chk($sformatf("bh%0d.fill", i),  32'(bus_b.fill), 32'(b_fill[i]));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
